// File: rtl/pio_pkg.sv
// pio_pkg: shared types and constants for the PIO register/table slave
package pio_pkg;

    typedef enum logic [1:0] {
        RGN_TBL,
        RGN_CTRL,
        RGN_REG,
        RGN_UNMAPPED
    } region_e;

    typedef enum logic {
        ST_IDLE,
        ST_INIT
    } state_e;

    localparam logic [31:0] RD_ERR_VAL     = 32'hDEAD_BEEF;
    localparam int          CTRL_CLR_BIT   = 0;
    localparam int          CTRL_BUSY_BIT  = 1;
    localparam int          CTRL_DEPTH_LSB = 8;
    localparam int          CTRL_DEPTH_MSB = 15;

endpackage

// File: rtl/pio_tbl_ram.sv
// pio_tbl_ram: 1R1W synchronous RAM with registered read and write-first bypass
module pio_tbl_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // write port, plus registered read that returns the incoming data on an address collision
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= (we_i && waddr_i == raddr_i) ? wdata_i : mem_q[raddr_i];
    end

endmodule

// File: rtl/pio_reg_table.sv
// pio_reg_table: PIO slave with data registers, CTRL/STATUS, an init-able table and error responses
module pio_reg_table
    import pio_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 16,
    parameter int                TBL_DEPTH = 1024,
    parameter int                NUM_REGS  = 4,
    parameter int                REG_BASE  = 'h1000,
    parameter logic [DATA_W-1:0] INIT_VAL  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pio_cmd_vld,
    input  logic              pio_rw,
    input  logic [ADDR_W-1:0] pio_addr,
    input  logic [DATA_W-1:0] pio_data_w,
    output logic [DATA_W-1:0] pio_data_r,
    output logic              pio_rd_vld,
    output logic              pio_rd_err,
    output logic              pio_busy
);

    localparam int IW = $clog2(TBL_DEPTH);
    localparam int RW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;

    state_e            state_q;
    logic [IW:0]       idx_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              s1_vld_q, s1_err_q, s1_tbl_q;
    logic [DATA_W-1:0] s1_dat_q;
    logic [DATA_W-1:0] ram_rdata;

    region_e           rgn_d;
    logic [ADDR_W-1:0] off_d;
    logic [RW-1:0]     ridx_d;
    logic [DATA_W-1:0] ctrl_d;
    logic              wr_d, rd_d, err_d, clr_d;
    logic              ram_we;
    logic [IW-1:0]     ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    assign pio_busy = state_q == ST_INIT;

    // address decode, command qualification and the shared RAM write-port mux
    always_comb begin
        off_d     = pio_addr - ADDR_W'(REG_BASE + 1);
        ridx_d    = off_d[RW-1:0];
        rgn_d     = pio_addr < ADDR_W'(TBL_DEPTH) ? RGN_TBL :
                    pio_addr == ADDR_W'(REG_BASE) ? RGN_CTRL :
                    (pio_addr > ADDR_W'(REG_BASE) && off_d < ADDR_W'(NUM_REGS)) ? RGN_REG : RGN_UNMAPPED;
        wr_d      = pio_cmd_vld && pio_rw;
        rd_d      = pio_cmd_vld && !pio_rw;
        err_d     = rgn_d == RGN_UNMAPPED || (rgn_d == RGN_TBL && pio_busy);
        clr_d     = wr_d && rgn_d == RGN_CTRL && pio_data_w[CTRL_CLR_BIT];
        ctrl_d    = '0;
        ctrl_d[CTRL_BUSY_BIT] = pio_busy;
        ctrl_d[CTRL_DEPTH_MSB:CTRL_DEPTH_LSB] = 8'(IW);
        ram_we    = pio_busy || (wr_d && rgn_d == RGN_TBL);
        ram_waddr = pio_busy ? idx_q[IW-1:0] : pio_addr[IW-1:0];
        ram_wdata = pio_busy ? INIT_VAL : pio_data_w;
    end

    // init engine: sweeps every table entry once after reset or a CLR, restarting on a new CLR
    always_ff @(posedge clk) begin
        if (reset || clr_d) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
        end else if (state_q == ST_INIT) begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == (IW + 1)'(TBL_DEPTH - 1)) state_q <= ST_IDLE;
        end
    end

    // data register writes
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wr_d && rgn_d == RGN_REG) begin
            regs_q[ridx_d] <= pio_data_w;
        end
    end

    // two-stage read pipeline: stage 1 captures register data and status, stage 2 is the output flop
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q   <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_tbl_q   <= 1'b0;
            s1_dat_q   <= '0;
            pio_rd_vld <= 1'b0;
            pio_rd_err <= 1'b0;
            pio_data_r <= '0;
        end else begin
            s1_vld_q   <= rd_d;
            s1_err_q   <= err_d;
            s1_tbl_q   <= rgn_d == RGN_TBL;
            s1_dat_q   <= rgn_d == RGN_CTRL ? ctrl_d : regs_q[ridx_d];
            pio_rd_vld <= s1_vld_q;
            pio_rd_err <= s1_vld_q && s1_err_q;
            if (s1_vld_q) pio_data_r <= s1_err_q ? DATA_W'(RD_ERR_VAL) : s1_tbl_q ? ram_rdata : s1_dat_q;
        end
    end

    pio_tbl_ram #(
        .DEPTH(TBL_DEPTH),
        .WIDTH(DATA_W)
    ) u_ram (
        .clk    (clk),
        .we_i   (ram_we),
        .waddr_i(ram_waddr),
        .wdata_i(ram_wdata),
        .re_i   (rd_d && rgn_d == RGN_TBL),
        .raddr_i(pio_addr[IW-1:0]),
        .rdata_o(ram_rdata)
    );

endmodule

// File: tb/tb_pio_reg_table.sv
// tb_pio_reg_table: directed stimulus with a queue-based response scoreboard
module tb_pio_reg_table;

    logic        clk = 1'b0;
    logic        reset;
    logic        pio_cmd_vld;
    logic        pio_rw;
    logic [15:0] pio_addr;
    logic [31:0] pio_data_w;
    logic [31:0] pio_data_r;
    logic        pio_rd_vld;
    logic        pio_rd_err;
    logic        pio_busy;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    pio_reg_table dut (
        .clk        (clk),
        .reset      (reset),
        .pio_cmd_vld(pio_cmd_vld),
        .pio_rw     (pio_rw),
        .pio_addr   (pio_addr),
        .pio_data_w (pio_data_w),
        .pio_data_r (pio_data_r),
        .pio_rd_vld (pio_rd_vld),
        .pio_rd_err (pio_rd_err),
        .pio_busy   (pio_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    // monitor: pops the scoreboard on every response and flags stray or missing responses
    always @(negedge clk) begin
        if (pio_rd_vld) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got data %h err %b want no response (cycle %0d)", pio_data_r, pio_rd_err, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_cycle", 32'(cyc), 32'(e.due));
                chk("rsp_err", {31'b0, pio_rd_err}, {31'b0, e.err});
                chk("rsp_data", pio_data_r, e.data);
            end
        end else if (q.size() > 0 && q[0].due < cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_missing", 32'(cyc), 32'(e.due));
        end
    end

    task automatic cmd(input logic rw, input logic [15:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        pio_cmd_vld = 1'b1;
        pio_rw      = rw;
        pio_addr    = a;
        pio_data_w  = d;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        cmd(1'b1, a, d);
    endtask

    task automatic rd(input logic [15:0] a, input logic err, input logic [31:0] d);
        cmd(1'b0, a, 32'h0);
        q.push_back('{err, d, cyc + 2});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            pio_cmd_vld = 1'b0;
            pio_rw      = 1'b0;
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!pio_busy) break;
            n++;
        end
    endtask

    task automatic wait_idle();
        int n;
        count_busy(n);
        if (pio_busy) chk("busy_timeout", 32'(pio_busy), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        int n;
        reset       = 1'b1;
        pio_cmd_vld = 1'b0;
        pio_rw      = 1'b0;
        pio_addr    = '0;
        pio_data_w  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_vld", {31'b0, pio_rd_vld}, 32'h0);
        chk("reset_rd_err", {31'b0, pio_rd_err}, 32'h0);
        chk("reset_data_r", pio_data_r, 32'h0);
        reset = 1'b0;
        count_busy(n);
        chk("init_busy_len", 32'(n), 32'd1024);
        rd(16'h03FF, 1'b0, 32'h0);
        rd(16'h1000, 1'b0, 32'h0000_0A00);
        idle(4);

        wr(16'h0005, 32'hA5A5_0001);
        rd(16'h0005, 1'b0, 32'hA5A5_0001);
        idle(1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("data_hold", pio_data_r, 32'hA5A5_0001);

        wr(16'h1001, 32'd1);
        wr(16'h1002, 32'd2);
        wr(16'h1003, 32'd3);
        wr(16'h1004, 32'd4);
        rd(16'h1001, 1'b0, 32'd1);
        rd(16'h1002, 1'b0, 32'd2);
        rd(16'h1003, 1'b0, 32'd3);
        rd(16'h1004, 1'b0, 32'd4);
        idle(4);

        rd(16'h2000, 1'b1, 32'hDEAD_BEEF);
        rd(16'h1005, 1'b1, 32'hDEAD_BEEF);
        wr(16'h2000, 32'hFFFF_FFFF);
        rd(16'h1001, 1'b0, 32'd1);
        rd(16'h1004, 1'b0, 32'd4);
        rd(16'h0005, 1'b0, 32'hA5A5_0001);
        idle(4);

        for (int i = 0; i < 1024; i++) wr(16'(i), 32'h1234);
        rd(16'h0007, 1'b0, 32'h1234);
        rd(16'h03FF, 1'b0, 32'h1234);
        wr(16'h1000, 32'h1);
        idle(3);
        rd(16'h0007, 1'b1, 32'hDEAD_BEEF);
        rd(16'h1000, 1'b0, 32'h0000_0A02);
        rd(16'h1002, 1'b0, 32'd2);
        wr(16'h0009, 32'h5555);
        idle(2);
        wait_idle();
        rd(16'h0007, 1'b0, 32'h0);
        rd(16'h0009, 1'b0, 32'h0);
        idle(4);

        wr(16'h1000, 32'h1);
        idle(498);
        rd(16'h1001, 1'b0, 32'd1);
        void'(q.pop_back());
        @(posedge clk);
        #1;
        pio_cmd_vld = 1'b0;
        reset       = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        count_busy(n);
        chk("reinit_busy_len", 32'(n), 32'd1024);
        rd(16'h1001, 1'b0, 32'h0);
        rd(16'h1002, 1'b0, 32'h0);
        rd(16'h1003, 1'b0, 32'h0);
        rd(16'h1004, 1'b0, 32'h0);
        idle(6);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
